// File: rtl/sym_classifier.sv
// Byte classifier in front of the string recognizer: buffers UART bytes in a FIFO,
// releases them with a minimum spacing and registers per-byte character-class flags.
module sym_classifier #(
  parameter int DEPTH   = 4,
  parameter int GAP     = 1,
  parameter int MAX_LEN = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     rx_frame_err,
  output logic                     valid,
  output logic                     error_verify,
  output logic                     start_stop,
  output logic                     small_letter,
  output logic                     capital_letter,
  output logic                     number,
  output logic                     hex_digit,
  output logic                     punctuation_basic,
  output logic                     punctuation_finance,
  output logic                     parentheses,
  output logic                     curly_braces,
  output logic                     math_symbol,
  output logic                     whitespace,
  output logic                     vowel,
  output logic                     consonant,
  output logic                     other,
  output logic [7:0]               char_out,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [2:0]    GAP_L   = 3'(GAP);
  localparam logic [8:0]    MAX_L   = 9'(MAX_LEN);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] count_q, count_d;
  logic [2:0]    gap_q, gap_d;
  logic [8:0]    len_q, len_d;
  logic [13:0]   flags_q, flags_d;
  logic [7:0]    char_q;
  logic          valid_q, err_q, ovf_q;

  logic [7:0] head;
  logic       pop, push_req, push, drop, len_err;

  always_comb begin
    head     = mem_q[rd_ptr_q];
    pop      = (count_q != '0) && (gap_q == 3'd0);
    push_req = rx_valid && !rx_frame_err;
    push     = push_req && ((count_q != DEPTH_L) || pop);
    drop     = push_req && (count_q == DEPTH_L) && !pop;
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_comb begin
    gap_d = gap_q;
    if (pop)                gap_d = GAP_L;
    else if (gap_q != 3'd0) gap_d = gap_q - 3'd1;
  end

  // Length saturates at MAX_LEN+1 so the error fires once per over-long string.
  always_comb begin
    len_d   = len_q;
    len_err = 1'b0;
    if (pop) begin
      if (head == 8'h00) begin
        len_d = 9'd0;
      end else if (len_q < MAX_L) begin
        len_d = len_q + 9'd1;
      end else if (len_q == MAX_L) begin
        len_d   = MAX_L + 9'd1;
        len_err = 1'b1;
      end
    end
  end

  logic f_ss, f_sm, f_cap, f_num, f_hex, f_pb, f_pf, f_par, f_cur, f_math, f_ws, f_vow, f_con, f_oth;
  always_comb begin
    f_ss   = (head == 8'h00);
    f_sm   = (head >= 8'h61) && (head <= 8'h7A);
    f_cap  = (head >= 8'h41) && (head <= 8'h5A);
    f_num  = (head >= 8'h30) && (head <= 8'h39);
    f_hex  = f_num || ((head >= 8'h41) && (head <= 8'h46)) || ((head >= 8'h61) && (head <= 8'h66));
    f_pb   = 1'b0;
    f_pf   = 1'b0;
    f_par  = 1'b0;
    f_cur  = 1'b0;
    f_math = 1'b0;
    f_ws   = 1'b0;
    f_vow  = 1'b0;
    case (head)
      8'h2E, 8'h2C, 8'h3A, 8'h3B, 8'h21, 8'h3F, 8'h27, 8'h22: f_pb = 1'b1;
      8'h23, 8'h24, 8'h25, 8'h26, 8'h40:                      f_pf = 1'b1;
      8'h28, 8'h29, 8'h5B, 8'h5D:                             f_par = 1'b1;
      8'h7B, 8'h7D:                                           f_cur = 1'b1;
      8'h2B, 8'h2D, 8'h2A, 8'h2F, 8'h5C, 8'h3D, 8'h3C, 8'h3E: f_math = 1'b1;
      8'h20, 8'h09, 8'h0A, 8'h0D:                             f_ws = 1'b1;
      8'h61, 8'h65, 8'h69, 8'h6F, 8'h75,
      8'h41, 8'h45, 8'h49, 8'h4F, 8'h55:                      f_vow = 1'b1;
      default: ;
    endcase
    f_con   = (f_sm || f_cap) && !f_vow;
    f_oth   = !(f_ss || f_sm || f_cap || f_num || f_pb || f_pf || f_par || f_cur || f_math || f_ws);
    flags_d = {f_ss, f_sm, f_cap, f_num, f_hex, f_pb, f_pf, f_par, f_cur, f_math, f_ws, f_vow, f_con, f_oth};
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      gap_q    <= 3'd0;
      len_q    <= 9'd0;
      flags_q  <= '0;
      char_q   <= 8'h00;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        flags_q  <= flags_d;
        char_q   <= head;
      end
      count_q <= count_d;
      gap_q   <= gap_d;
      len_q   <= len_d;
      valid_q <= pop;
      err_q   <= rx_frame_err || drop || len_err;
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign {start_stop, small_letter, capital_letter, number, hex_digit, punctuation_basic,
          punctuation_finance, parentheses, curly_braces, math_symbol, whitespace,
          vowel, consonant, other} = flags_q;
  assign valid        = valid_q;
  assign error_verify = err_q;
  assign char_out     = char_q;
  assign fifo_level   = count_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_sym_classifier.sv
// Randomized and directed bench for sym_classifier against a queue-based reference model.
module tb_sym_classifier;

  localparam int DEPTH   = 4;
  localparam int GAP     = 2;
  localparam int MAX_LEN = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0;
  logic rx_frame_err = 1'b0;
  logic valid, error_verify, start_stop, small_letter, capital_letter, number, hex_digit;
  logic punctuation_basic, punctuation_finance, parentheses, curly_braces, math_symbol;
  logic whitespace, vowel, consonant, other, overflow;
  logic [7:0] char_out;
  logic [$clog2(DEPTH):0] fifo_level;

  sym_classifier #(.DEPTH(DEPTH), .GAP(GAP), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err),
    .valid(valid), .error_verify(error_verify), .start_stop(start_stop),
    .small_letter(small_letter), .capital_letter(capital_letter), .number(number),
    .hex_digit(hex_digit), .punctuation_basic(punctuation_basic),
    .punctuation_finance(punctuation_finance), .parentheses(parentheses),
    .curly_braces(curly_braces), .math_symbol(math_symbol), .whitespace(whitespace),
    .vowel(vowel), .consonant(consonant), .other(other), .char_out(char_out),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model state: byte queue, spacing countdown, string length.
  logic [7:0]  exp_q[$];
  int          m_gap = 0;
  int          m_len = 0;
  logic        exp_valid = 0, exp_err = 0, exp_ovf = 0;
  logic [13:0] exp_flags = '0;
  logic [7:0]  exp_char = 8'h00;

  int cnt_valid = 0, cnt_err = 0, peak = 0;

  function automatic bit in_set(input logic [7:0] c, input string s);
    for (int i = 0; i < s.len(); i++)
      if (s[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [13:0] ref_class(input logic [7:0] c);
    bit ss, lo, up, num, hex, pb, pf, par, cur, mth, ws, vow, con, oth;
    ss  = (c == 8'h00);
    lo  = c inside {[8'h61:8'h7A]};
    up  = c inside {[8'h41:8'h5A]};
    num = c inside {[8'h30:8'h39]};
    hex = in_set(c, "0123456789ABCDEFabcdef");
    pb  = in_set(c, ".,:;!?'") || (c == 8'h22);
    pf  = in_set(c, "#$%&@");
    par = in_set(c, "()[]");
    cur = in_set(c, "{}");
    mth = in_set(c, "+-*/=<>") || (c == 8'h5C);
    ws  = (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D);
    vow = in_set(c, "aeiouAEIOU");
    con = (lo || up) && !vow;
    oth = !(ss || lo || up || num || pb || pf || par || cur || mth || ws);
    return {ss, lo, up, num, hex, pb, pf, par, cur, mth, ws, vow, con, oth};
  endfunction

  task automatic model_step(input logic r, input logic v, input logic [7:0] d, input logic fe);
    bit pop, push, ovf, lerr;
    logic [7:0] c;
    if (r) begin
      exp_q.delete();
      m_gap = 0; m_len = 0;
      exp_valid = 0; exp_err = 0; exp_ovf = 0; exp_flags = '0; exp_char = 8'h00;
    end else begin
      pop  = (exp_q.size() > 0) && (m_gap == 0);
      push = v && !fe;
      ovf  = push && (exp_q.size() == DEPTH) && !pop;
      lerr = 0;
      if (pop) begin
        c = exp_q.pop_front();
        exp_char  = c;
        exp_flags = ref_class(c);
        exp_valid = 1;
        m_gap     = GAP;
        if (c == 8'h00) m_len = 0;
        else begin
          m_len++;
          if (m_len == MAX_LEN + 1) lerr = 1;
          if (m_len > MAX_LEN + 1) m_len = MAX_LEN + 1;
        end
      end else begin
        exp_valid = 0;
        if (m_gap > 0) m_gap--;
      end
      if (push && exp_q.size() < DEPTH) exp_q.push_back(d);
      if (ovf) exp_ovf = 1;
      exp_err = fe || ovf || lerr;
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [7:0] d, input logic fe);
    logic [13:0] dut_flags;
    rst = r; rx_valid = v; rx_data = d; rx_frame_err = fe;
    @(posedge clk);
    model_step(r, v, d, fe);
    @(negedge clk);
    dut_flags = {start_stop, small_letter, capital_letter, number, hex_digit, punctuation_basic,
                 punctuation_finance, parentheses, curly_braces, math_symbol, whitespace,
                 vowel, consonant, other};
    check("valid", 32'(valid), 32'(exp_valid));
    check("error_verify", 32'(error_verify), 32'(exp_err));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
    check("flags", 32'(dut_flags), 32'(exp_flags));
    check("char_out", 32'(char_out), 32'(exp_char));
    cnt_valid += int'(valid);
    cnt_err   += int'(error_verify);
    if (int'(fifo_level) > peak) peak = int'(fifo_level);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic clear_counts();
    cnt_valid = 0; cnt_err = 0; peak = 0;
  endtask

  initial begin
    logic [7:0] s1 [5];
    logic [7:0] s4 [4];
    logic [7:0] slen [8];
    logic [7:0] special [6];
    string pool;

    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    check("reset_level", 32'(fifo_level), 32'd0);

    // Spaced string: zero, a, b, a, zero
    s1 = '{8'h00, 8'h61, 8'h62, 8'h61, 8'h00};
    clear_counts();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, s1[i], 1'b0);
      idle(4);
    end
    idle(6);
    check("spaced_valid_count", 32'(cnt_valid), 32'd5);
    check("spaced_err_count", 32'(cnt_err), 32'd0);

    // Back-to-back burst of 4: spacing limits pops, level peaks at 3
    s4 = '{8'h41, 8'h31, 8'h2E, 8'h28};
    clear_counts();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, s4[i], 1'b0);
    idle(15);
    check("burst4_peak", 32'(peak), 32'd3);
    check("burst4_valid_count", 32'(cnt_valid), 32'd4);
    check("burst4_overflow", 32'(overflow), 32'd0);

    // Burst of 7 overruns the 4-entry FIFO by one byte
    clear_counts();
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
    idle(25);
    check("burst7_valid_count", 32'(cnt_valid), 32'd6);
    check("burst7_err_count", 32'(cnt_err), 32'd1);
    check("burst7_overflow", 32'(overflow), 32'd1);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);

    // Over-long string then a short one
    slen = '{8'h78, 8'h79, 8'h7A, 8'h77, 8'h00, 8'h61, 8'h62, 8'h00};
    clear_counts();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, slen[i], 1'b0);
      idle(3);
    end
    idle(4);
    check("len_err_count", 32'(cnt_err), 32'd1);
    check("len_valid_count", 32'(cnt_valid), 32'd5);
    clear_counts();
    for (int i = 5; i < 8; i++) begin
      cycle(1'b0, 1'b1, slen[i], 1'b0);
      idle(3);
    end
    idle(4);
    check("short_err_count", 32'(cnt_err), 32'd0);
    check("short_valid_count", 32'(cnt_valid), 32'd3);

    // Frame error with a coincident byte
    clear_counts();
    cycle(1'b0, 1'b1, 8'h51, 1'b1);
    idle(6);
    check("frame_valid_count", 32'(cnt_valid), 32'd0);
    check("frame_err_count", 32'(cnt_err), 32'd1);

    // Mid-stream reset discards queued bytes
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'(8'h61 + i), 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    clear_counts();
    idle(10);
    check("rst_valid_count", 32'(cnt_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);

    // Random traffic
    pool    = "aeiouxyzAEQZ09fF.,:;!?'#$%&@()[]{}+-*/=<>~_^`|";
    special = '{8'h22, 8'h5C, 8'h20, 8'h09, 8'h0A, 8'h0D};
    for (int i = 0; i < 600; i++) begin
      logic r, v, fe;
      logic [7:0] d;
      r  = ($urandom_range(0, 149) == 0);
      v  = ($urandom_range(0, 3) == 0);
      fe = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 4))
        0:       d = 8'h00;
        1:       d = 8'($urandom_range(0, 255));
        2:       d = special[$urandom_range(0, 5)];
        default: d = pool[$urandom_range(0, pool.len() - 1)];
      endcase
      cycle(r, v, d, fe);
    end
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sym_classifier.md
# sym_classifier

Upstream stage of the string-recognizer FSM. Accepts raw bytes from the UART receiver, buffers them in a small FIFO, and classifies each byte into the registered character-class flags the FSM consumes. Issues one `valid` pulse per byte with a guaranteed minimum spacing. Raises `error_verify` on receive faults, FIFO overflow and over-long strings.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `GAP`, 1: minimum idle cycles between two `valid` pulses; 0..7.
- `MAX_LEN`, 15: maximum non-`\0` bytes per string; 1..255.

Ports (`clk`/`rst`: one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous active-high reset.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid while high.
- `rx_frame_err` in 1: one-cycle strobe; UART stop-bit error.
- `valid` out 1: one-cycle pulse; class flags describe a new byte.
- `error_verify` out 1: one-cycle error pulse.
- `start_stop`, `small_letter`, `capital_letter`, `number`, `hex_digit`, `punctuation_basic`, `punctuation_finance`, `parentheses`, `curly_braces`, `math_symbol`, `whitespace`, `vowel`, `consonant`, `other` out 1 each: registered class flags.
- `char_out` out 8: registered byte behind the current flags.
- `fifo_level` out clog2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky flag; a byte was dropped.

## Operation
- Classification of the popped byte (ASCII):
  - `start_stop` = 0x00.
  - `small_letter` = a–z. `capital_letter` = A–Z. `number` = 0–9.
  - `hex_digit` = 0–9, A–F, a–f.
  - `punctuation_basic` = . , : ; ! ? ' ".
  - `punctuation_finance` = # $ % & @.
  - `parentheses` = ( ) [ ]. `curly_braces` = { }.
  - `math_symbol` = + - * / \ = < >.
  - `whitespace` = 0x20, 0x09, 0x0A, 0x0D.
  - `vowel` = aeiouAEIOU. `consonant` = any letter that is not a vowel.
  - `other` = none of `start_stop`, letter, `number`, or the six punctuation/symbol/whitespace groups.
  - Flags may overlap (e.g. 'a' sets `small_letter`, `hex_digit`, `vowel`).
- FIFO:
  - Push when `rx_valid`.
  - Pop when the FIFO is not empty and the gap counter is 0.
  - Push while full with a simultaneous pop: accepted.
  - Push while full without a pop: byte dropped, `overflow` set (sticky until `rst`), `error_verify` pulses.
- Gap counter:
  - Loaded with `GAP` on each pop; decrements to 0.
  - `GAP`=0 allows back-to-back pulses.
- Length counter:
  - Counts popped non-`\0` bytes; a popped `\0` clears it.
  - The pop that would make the count `MAX_LEN`+1 pulses `error_verify`. The count saturates until the next `\0`, with no further pulses in the same string.
  - That byte is still emitted with `valid`.
- `rx_frame_err` pulses `error_verify` on the next cycle. The faulty byte is not pushed, even if `rx_valid` coincides.
- Several error causes in one cycle produce a single `error_verify` pulse.

## Timing
- Reset values:
  - All flags, `char_out`, `valid`, `error_verify` and `overflow` = 0.
  - FIFO empty, `fifo_level` = 0.
  - Gap and length counters = 0.
- Latency: byte strobed at edge N on an empty, idle FIFO → `valid` and flags high in the cycle after edge N+1.
- Flags and `char_out` hold their value until the next pop; `valid` is high for exactly 1 cycle.
- `error_verify` is registered: 1 cycle after the causing event, high for exactly 1 cycle.
- `fifo_level` updates on the edge after each push or pop. A simultaneous push and pop leaves it unchanged.
- `rst` in mid-stream:
  - The FIFO contents are discarded; no `valid` pulse appears in the cycle after `rst`.
  - A pending `error_verify` is cancelled.

## Test plan
- Reset, then strobe 0x00,'a','b','a',0x00 spaced 5 cycles apart → 5 `valid` pulses.
  - Flags per pulse: `start_stop`; small+hex+vowel; small+hex+consonant; small+hex+vowel; `start_stop`.
  - `error_verify` never asserted.
- `GAP`=2: burst of 4 bytes on consecutive cycles → `valid` pulses 3 cycles apart, `fifo_level` peaks at 3, `overflow`=0.
- `DEPTH`=4, `GAP`=7: burst of 6 bytes → 1 byte dropped, `overflow`=1, `error_verify` pulses once, 5 `valid` pulses.
- `MAX_LEN`=3: strobe 'x','y','z','w',0x00 → `error_verify` 1 cycle after 'w' is popped; 'w' still emitted; the following `\0` clears the count; a subsequent "ab\0" raises no error.
- `rx_frame_err` together with `rx_valid`=1 and byte 'Q' → no `valid` pulse for 'Q', `error_verify` high for 1 cycle.
- 3 bytes queued, `rst` for 1 cycle → all outputs 0, no `valid` pulses afterwards, `fifo_level`=0.
